// File: rtl/chroni_vram_arbiter_if.sv
// chroni_vram_arbiter_if
//   Bundles the signals around chroni's shared VRAM read port. The requester
//   side carries three request channels and the shared completion signals. The
//   memory side carries the single VRAM read port.
//
//   Handshake: a requester raises req[i] and holds req, address and page stable
//   until it samples ack[i] high. It drops req[i] on that same clock edge. The
//   arbiter raises mem_rd_req as a level and holds it until the clock edge that
//   samples mem_rd_ack, or until the timeout expires. mem_data is valid only in
//   the cycle where mem_rd_ack is high. ack is a one-cycle, one-hot pulse.
//   rd_data and ack_err are valid only while ack != 0.
//
//   Modports:
//     slave  - the arbiter's view (requests and memory responses are inputs)
//     master - the environment's view (requesters plus the memory device)
interface chroni_vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int PAGE_W = 8,
  parameter int DATA_W = 8
);
  // requester side
  logic [2:0]          req;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*PAGE_W-1:0] req_page;
  logic [2:0]          ack;
  logic                ack_err;
  logic [DATA_W-1:0]   rd_data;
  logic [2:0]          grant;
  // memory side
  logic [ADDR_W-1:0]   mem_addr;
  logic [PAGE_W-1:0]   mem_page;
  logic                mem_rd_req;
  logic                mem_rd_ack;
  logic [DATA_W-1:0]   mem_data;

  modport slave (
    input  req, req_addr, req_page, mem_rd_ack, mem_data,
    output ack, ack_err, rd_data, grant, mem_addr, mem_page, mem_rd_req
  );

  modport master (
    output req, req_addr, req_page, mem_rd_ack, mem_data,
    input  ack, ack_err, rd_data, grant, mem_addr, mem_page, mem_rd_req
  );
endinterface

// File: rtl/chroni_vram_arbiter.sv
// chroni_vram_arbiter
//   Shares chroni's single VRAM read port between three requesters:
//     port 0 = display fetch (text/font), port 1 = sprite fetch,
//     port 2 = CPU read-back.
//   Port 0 has strict priority. A starvation guard hands one slot to port 1 or
//   port 2 after STARVE_LIMIT consecutive port-0 grants made while either of
//   them was waiting. Ports 1 and 2 alternate round-robin. A memory timeout
//   completes a read with ack_err=1 when mem_rd_ack never arrives. Because of
//   this, a lost ack cannot stall display fetch.
//
// Ports
//   vga_clk    in   clock, rising edge
//   reset_n    in   synchronous, active-low reset
//   bus        slave modport of chroni_vram_arbiter_if:
//                req/req_addr/req_page in, ack/ack_err/rd_data/grant out,
//                mem_addr/mem_page/mem_rd_req out, mem_rd_ack/mem_data in
//   state_dbg  out  current FSM state (0 IDLE, 1 BUSY, 2 ACK)
//
// Sequence: IDLE -> BUSY -> ACK -> IDLE. mem_rd_req always drops for at least
// one cycle between two reads.
module chroni_vram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int PAGE_W       = 8,
  parameter int DATA_W       = 8,
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  chroni_vram_arbiter_if.slave  bus,
  output logic [1:0]            state_dbg
);

  localparam int              SC_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [15:0]     TO_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [2:0]        ack_q, ack_d;
  logic              ack_err_q, ack_err_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PAGE_W-1:0] mem_page_q, mem_page_d;
  logic              mem_rd_req_q, mem_rd_req_d;
  // rr_q: 0 = port 1 wins the next 1-vs-2 tie, 1 = port 2 wins it
  logic              rr_q, rr_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [15:0]       to_q, to_d;

  logic              pend12;
  logic [2:0]        rr_pick;
  logic [2:0]        win;
  logic [ADDR_W-1:0] win_addr;
  logic [PAGE_W-1:0] win_page;

  // Winner selection. This block is purely combinational on the current
  // requests. It only takes effect when the FSM sits in IDLE.
  always_comb begin
    pend12  = bus.req[1] | bus.req[2];
    rr_pick = 3'b000;
    if (bus.req[1] && bus.req[2]) begin
      rr_pick = rr_q ? 3'b100 : 3'b010;
    end else if (bus.req[1]) begin
      rr_pick = 3'b010;
    end else if (bus.req[2]) begin
      rr_pick = 3'b100;
    end

    // The starvation guard overrides port-0 priority only when someone on
    // port 1 or port 2 is actually waiting.
    if (starve_q == STARVE_MAX && pend12) begin
      win = rr_pick;
    end else if (bus.req[0]) begin
      win = 3'b001;
    end else begin
      win = rr_pick;
    end
  end

  // Address/page mux for the chosen port.
  always_comb begin
    win_addr = bus.req_addr[0 +: ADDR_W];
    win_page = bus.req_page[0 +: PAGE_W];
    if (win[1]) begin
      win_addr = bus.req_addr[ADDR_W +: ADDR_W];
      win_page = bus.req_page[PAGE_W +: PAGE_W];
    end else if (win[2]) begin
      win_addr = bus.req_addr[2*ADDR_W +: ADDR_W];
      win_page = bus.req_page[2*PAGE_W +: PAGE_W];
    end
  end

  // Next-state and next-output logic. Every output is registered. For that
  // reason this block computes the value each register takes at the next edge.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ack_d        = 3'b000;
    ack_err_d    = 1'b0;
    rd_data_d    = rd_data_q;
    mem_addr_d   = mem_addr_q;
    mem_page_d   = mem_page_q;
    mem_rd_req_d = mem_rd_req_q;
    rr_d         = rr_q;
    starve_d     = starve_q;
    to_d         = to_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req != 3'b000) begin
          grant_d      = win;
          mem_addr_d   = win_addr;
          mem_page_d   = win_page;
          mem_rd_req_d = 1'b1;
          to_d         = 16'd0;
          state_d      = ST_BUSY;
          if (win[0]) begin
            // Count only the port-0 grants that made another port wait.
            if (!pend12) begin
              starve_d = '0;
            end else if (starve_q != STARVE_MAX) begin
              starve_d = starve_q + SC_W'(1);
            end
          end else begin
            starve_d = '0;
            // After serving port 1, port 2 wins the next tie, and vice versa.
            rr_d     = win[1];
          end
        end
      end

      ST_BUSY: begin
        // A real ack wins over a timeout expiring in the same cycle.
        if (bus.mem_rd_ack) begin
          rd_data_d    = bus.mem_data;
          ack_d        = grant_q;
          mem_rd_req_d = 1'b0;
          state_d      = ST_ACK;
        end else if (to_q == TO_LAST) begin
          rd_data_d    = '0;
          ack_d        = grant_q;
          ack_err_d    = 1'b1;
          mem_rd_req_d = 1'b0;
          state_d      = ST_ACK;
        end else begin
          to_d = to_q + 16'd1;
        end
      end

      ST_ACK: begin
        // grant is held through the ACK cycle so that it lines up with ack.
        grant_d = 3'b000;
        state_d = ST_IDLE;
      end

      default: begin
        grant_d      = 3'b000;
        mem_rd_req_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // A reset in BUSY drops the read without an ack. mem_rd_ack is ignored
  // outside BUSY, so a late ack from the aborted read has no effect.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 3'b000;
      ack_q        <= 3'b000;
      ack_err_q    <= 1'b0;
      rd_data_q    <= '0;
      mem_addr_q   <= '0;
      mem_page_q   <= '0;
      mem_rd_req_q <= 1'b0;
      rr_q         <= 1'b0;
      starve_q     <= '0;
      to_q         <= 16'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      ack_err_q    <= ack_err_d;
      rd_data_q    <= rd_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_page_q   <= mem_page_d;
      mem_rd_req_q <= mem_rd_req_d;
      rr_q         <= rr_d;
      starve_q     <= starve_d;
      to_q         <= to_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.ack        = ack_q;
  assign bus.ack_err    = ack_err_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_page   = mem_page_q;
  assign bus.mem_rd_req = mem_rd_req_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_chroni_vram_arbiter.sv
module tb_chroni_vram_arbiter;
  localparam int ADDR_W       = 13;
  localparam int PAGE_W       = 8;
  localparam int DATA_W       = 8;
  localparam int TIMEOUT      = 8;
  localparam int STARVE_LIMIT = 4;
  localparam int W            = 3 + 1 + DATA_W;  // {ack, ack_err, rd_data}

  // ---------------- clock / reset ----------------
  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] state_dbg;

  always #5 vga_clk = ~vga_clk;

  chroni_vram_arbiter_if #(.ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .DATA_W(DATA_W)) bus();

  chroni_vram_arbiter #(
    .ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .DATA_W(DATA_W),
    .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .vga_clk  (vga_clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_pass  = 0;
  int           n_total = 0;

  // ---------------- requester / memory model state ----------------
  logic [2:0] hold = 3'b000;   // ports that keep requesting after ack
  bit         mem_en = 1'b1;   // memory answers at all
  int         mem_k = 0;       // cycles of mem_rd_req before ack
  bit         mem_ovr = 1'b0;  // return mem_ovr_val instead of addr^page
  logic [7:0] mem_ovr_val = 8'h00;
  bit         late_ack = 1'b0; // one stray mem_rd_ack pulse next cycle
  int         mem_wait = 0;
  bit         mem_done = 1'b0;
  int         req_hi_cnt = 0;  // cycles with mem_rd_req high

  // Data per port: addr[7:0]^page -> p0 0x11, p1 0x22, p2 0x04
  localparam logic [7:0] D0 = 8'h11;
  localparam logic [7:0] D1 = 8'h22;
  localparam logic [7:0] D2 = 8'h04;

  function automatic logic [W-1:0] exp_word(input logic [2:0] p, input logic e,
                                            input logic [7:0] d);
    return {p, e, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One cycle: advance to the negedge, then act as requesters and memory.
  task automatic tick();
    @(negedge vga_clk);
    for (int i = 0; i < 3; i++)
      if (bus.ack[i] && !hold[i]) bus.req[i] = 1'b0;
    bus.mem_rd_ack = 1'b0;
    if (late_ack) begin
      bus.mem_rd_ack = 1'b1;
      bus.mem_data   = 8'hEE;
      late_ack       = 1'b0;
    end else if (bus.mem_rd_req) begin
      req_hi_cnt++;
      if (mem_en && !mem_done) begin
        if (mem_wait == mem_k) begin
          bus.mem_rd_ack = 1'b1;
          bus.mem_data   = mem_ovr ? mem_ovr_val : (bus.mem_addr[7:0] ^ bus.mem_page);
          mem_done       = 1'b1;
        end else begin
          mem_wait++;
        end
      end
    end else begin
      mem_wait = 0;
      mem_done = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks until an ack is visible (at least one tick); lat = ticks taken.
  task automatic wait_ack(input string name, input int max_cyc, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus.ack == 3'b000 && lat < max_cyc);
    if (bus.ack == 3'b000) begin
      n_total++;
      $display("FAIL %s: no ack within %0d cycles", name, max_cyc);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    forever begin
      @(negedge vga_clk);
      if (bus.ack != 3'b000) begin
        got = {bus.ack, bus.ack_err, bus.rd_data};
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ack: got 0x%0h expected no ack", got);
        end else begin
          exp = exp_q.pop_front();
          check("ack_resp", 32'(got), 32'(exp));
          check("grant_in_ack", 32'(bus.grant), 32'(exp[W-1 -: 3]));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    bus.req        = 3'b111;
    bus.req_addr   = {13'h0401, 13'h0120, 13'h0010};
    bus.req_page   = {8'h05, 8'h02, 8'h01};
    bus.mem_rd_ack = 1'b0;
    bus.mem_data   = 8'h00;

    // 1: reset with all requests high
    ticks(2);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_ack_err", 32'(bus.ack_err), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_page", 32'(bus.mem_page), 0);
    check("rst_mem_rd_req", 32'(bus.mem_rd_req), 0);
    check("rst_state", 32'(state_dbg), 0);
    exp_q.push_back(exp_word(3'b001, 1'b0, D0));
    exp_q.push_back(exp_word(3'b010, 1'b0, D1));
    exp_q.push_back(exp_word(3'b100, 1'b0, D2));
    reset_n = 1'b1;
    tick();
    check("rel_grant", 32'(bus.grant), 32'h1);
    check("rel_mem_addr", 32'(bus.mem_addr), 32'h0010);
    check("rel_mem_rd_req", 32'(bus.mem_rd_req), 1);
    for (int i = 0; i < 3; i++) wait_ack("t1_ack", 20, lat);
    ticks(2);

    // 2: single read on port 2, k=2, data 0xA5
    mem_k = 2; mem_ovr = 1'b1; mem_ovr_val = 8'hA5;
    check("t2_idle_rd_req", 32'(bus.mem_rd_req), 0);
    exp_q.push_back(exp_word(3'b100, 1'b0, 8'hA5));
    bus.req = 3'b100;
    tick();
    check("t2_mem_rd_req", 32'(bus.mem_rd_req), 1);
    check("t2_mem_addr", 32'(bus.mem_addr), 32'h0401);
    check("t2_mem_page", 32'(bus.mem_page), 32'h05);
    check("t2_grant", 32'(bus.grant), 32'h4);
    wait_ack("t2_ack", 20, lat);
    check("t2_latency", 32'(lat + 1), 4);
    tick();
    check("t2_ack_pulse", 32'(bus.ack), 0);
    check("t2_rd_data_hold", 32'(bus.rd_data), 32'hA5);
    check("t2_grant_clear", 32'(bus.grant), 0);
    mem_k = 0; mem_ovr = 1'b0;
    ticks(2);

    // 4: round-robin, ports 1 and 2 held
    hold = 3'b110; bus.req = 3'b110;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(exp_word((i % 2 == 0) ? 3'b010 : 3'b100, 1'b0, (i % 2 == 0) ? D1 : D2));
    for (int i = 0; i < 4; i++) wait_ack("t4_ack", 20, lat);
    hold = 3'b000; bus.req = 3'b000;
    ticks(2);

    // 3: starvation guard, ports 0 and 1 held, k=0
    hold = 3'b011; bus.req = 3'b011;
    for (int i = 0; i < 10; i++)
      exp_q.push_back(exp_word((i % 5 == 4) ? 3'b010 : 3'b001, 1'b0, (i % 5 == 4) ? D1 : D0));
    for (int i = 0; i < 10; i++) wait_ack("t3_ack", 20, lat);
    hold = 3'b000; bus.req = 3'b000;
    ticks(2);

    // 5: timeout, memory silent
    mem_en = 1'b0; req_hi_cnt = 0;
    exp_q.push_back(exp_word(3'b001, 1'b1, 8'h00));
    bus.req = 3'b001;
    wait_ack("t5_ack", 30, lat);
    check("t5_latency", 32'(lat), 9);
    check("t5_rd_req_cycles", 32'(req_hi_cnt), 8);
    ticks(2);
    mem_en = 1'b1;
    exp_q.push_back(exp_word(3'b010, 1'b0, D1));
    bus.req = 3'b010;
    wait_ack("t5_next_ack", 20, lat);
    check("t5_next_latency", 32'(lat), 2);
    ticks(2);

    // 5b: ack in the same cycle the timeout would expire -> normal ack
    mem_k = TIMEOUT - 1; mem_ovr = 1'b1; mem_ovr_val = 8'h5A;
    exp_q.push_back(exp_word(3'b100, 1'b0, 8'h5A));
    bus.req = 3'b100;
    wait_ack("t5b_ack", 30, lat);
    check("t5b_latency", 32'(lat), 9);
    mem_k = 0; mem_ovr = 1'b0;
    ticks(2);

    // 6: reset mid-BUSY then a late mem_rd_ack
    mem_en = 1'b0;
    bus.req = 3'b010;
    ticks(2);
    check("t6_busy_state", 32'(state_dbg), 1);
    check("t6_busy_rd_req", 32'(bus.mem_rd_req), 1);
    reset_n = 1'b0; bus.req = 3'b000;
    tick();
    reset_n = 1'b1;
    late_ack = 1'b1;
    ticks(2);
    check("t6_state_idle", 32'(state_dbg), 0);
    check("t6_no_ack", 32'(bus.ack), 0);
    check("t6_grant", 32'(bus.grant), 0);
    check("t6_rd_req", 32'(bus.mem_rd_req), 0);
    mem_en = 1'b1;
    exp_q.push_back(exp_word(3'b100, 1'b0, D2));
    bus.req = 3'b100;
    wait_ack("t6_next_ack", 20, lat);
    check("t6_next_latency", 32'(lat), 2);
    ticks(3);

    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
